// File: rtl/tmr_scrub_ctrl_pkg.sv
// Shared types for the TMR scrubbing controller: FSM states, replica index
// and the one-hot load-strobe helper.
package tmr_pkg;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        RESYNC  = 2'd1,
        NOMAJ   = 2'd2,
        FAIL    = 2'd3
    } tmr_state_e;

    typedef logic [1:0] replica_idx_t;

    function automatic logic [2:0] onehot(input replica_idx_t idx);
        onehot = 3'b001 << idx;
    endfunction

endpackage

// File: rtl/tmr_scrub_ctrl_if.sv
// Bundle between the three replica counters / system side and the scrubber.
// The slave modport is the controller's view; master is the surrounding system.
interface tmr_scrub_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 4
);
    logic                   enable;
    logic [WIDTH-1:0]       q1;
    logic [WIDTH-1:0]       q2;
    logic [WIDTH-1:0]       q3;
    logic                   cnt_en;
    logic [2:0]             load_en;
    logic [WIDTH-1:0]       load_val;
    logic [WIDTH-1:0]       q_out;
    logic                   err_pulse;
    logic                   fail;
    logic [3*ERR_CNT_W-1:0] fault_cnt;
    logic [1:0]             state;

    modport master (
        output enable, q1, q2, q3,
        input  cnt_en, load_en, load_val, q_out, err_pulse, fail, fault_cnt, state
    );

    modport slave (
        input  enable, q1, q2, q3,
        output cnt_en, load_en, load_val, q_out, err_pulse, fail, fault_cnt, state
    );
endinterface

// File: rtl/tmr_scrub_ctrl_majority_voter.sv
// Purely combinational 2-of-3 voter: majority value, agreement flags and
// the index of the single disagreeing replica (0 = q1).
module tmr_majority_voter
    import tmr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q1,
    input  logic [WIDTH-1:0] i_q2,
    input  logic [WIDTH-1:0] i_q3,
    output logic [WIDTH-1:0] o_maj,
    output logic             o_all_eq,
    output logic             o_no_maj,
    output replica_idx_t     o_odd_idx
);

    logic w_eq12;
    logic w_eq13;
    logic w_eq23;

    assign w_eq12   = (i_q1 == i_q2);
    assign w_eq13   = (i_q1 == i_q3);
    assign w_eq23   = (i_q2 == i_q3);
    assign o_all_eq = w_eq12 && w_eq13;
    assign o_no_maj = !(w_eq12 || w_eq13 || w_eq23);

    // odd_idx only carries meaning when exactly one replica disagrees
    always_comb begin
        o_maj     = i_q1;
        o_odd_idx = 2'd0;
        if (w_eq12 && w_eq13) begin
            o_maj     = i_q1;
            o_odd_idx = 2'd0;
        end else if (w_eq12) begin
            o_maj     = i_q1;
            o_odd_idx = 2'd2;
        end else if (w_eq13) begin
            o_maj     = i_q1;
            o_odd_idx = 2'd1;
        end else if (w_eq23) begin
            o_maj     = i_q2;
            o_odd_idx = 2'd0;
        end
    end

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Scrubbing controller for a triplicated counter: votes the replicas, reloads a
// single stray replica, counts faults and latches a sticky failure.
module tmr_scrub_ctrl
    import tmr_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ERR_CNT_W  = 4,
    parameter int FAIL_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    tmr_scrub_if.slave  bus
);

    localparam logic [1:0] ST_MONITOR = MONITOR;
    localparam logic [1:0] ST_RESYNC  = RESYNC;
    localparam logic [1:0] ST_NOMAJ   = NOMAJ;
    localparam logic [1:0] ST_FAIL    = FAIL;

    localparam int                   NMW         = $clog2(FAIL_LIMIT + 1);
    localparam logic [NMW-1:0]       NOMAJ_LIMIT = NMW'(FAIL_LIMIT);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;

    logic [1:0]           r_state;
    replica_idx_t         r_sel;
    logic [NMW-1:0]       r_nomaj_cnt;
    logic [ERR_CNT_W-1:0] r_fault_cnt [3];
    logic [WIDTH-1:0]     r_q_out;
    logic                 r_fail;

    logic [WIDTH-1:0]     w_maj;
    logic                 w_all_eq;
    logic                 w_no_maj;
    replica_idx_t         w_odd_idx;

    logic [1:0]           w_next_state;
    replica_idx_t         w_next_sel;
    logic [NMW-1:0]       w_next_nomaj;
    logic                 w_fault_inc;
    logic                 w_cnt_en;
    logic [2:0]           w_load_en;
    logic                 w_err_pulse;

    tmr_majority_voter #(.WIDTH(WIDTH)) u_voter (
        .i_q1      (bus.q1),
        .i_q2      (bus.q2),
        .i_q3      (bus.q3),
        .o_maj     (w_maj),
        .o_all_eq  (w_all_eq),
        .o_no_maj  (w_no_maj),
        .o_odd_idx (w_odd_idx)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_sel   = r_sel;
        w_next_nomaj = r_nomaj_cnt;
        w_fault_inc  = 1'b0;
        w_cnt_en     = 1'b0;
        w_load_en    = 3'b000;
        w_err_pulse  = 1'b0;
        case (r_state)
            ST_MONITOR: begin
                w_cnt_en = bus.enable;
                if (w_no_maj) begin
                    w_next_state = ST_NOMAJ;
                    w_next_nomaj = NMW'(1);
                    w_err_pulse  = 1'b1;
                end else if (!w_all_eq) begin
                    w_next_state = ST_RESYNC;
                    w_next_sel   = w_odd_idx;
                    w_fault_inc  = 1'b1;
                    w_err_pulse  = 1'b1;
                end
            end
            // Good replicas are frozen here, so the live majority is the reload value
            ST_RESYNC: begin
                if (w_no_maj) begin
                    w_next_state = ST_NOMAJ;
                    w_next_nomaj = NMW'(1);
                    w_err_pulse  = 1'b1;
                end else begin
                    w_load_en    = onehot(r_sel);
                    w_next_state = ST_MONITOR;
                end
            end
            ST_NOMAJ: begin
                if (w_all_eq) begin
                    w_next_state = ST_MONITOR;
                end else if (!w_no_maj) begin
                    w_next_state = ST_RESYNC;
                    w_next_sel   = w_odd_idx;
                    w_fault_inc  = 1'b1;
                    w_err_pulse  = 1'b1;
                end else if (r_nomaj_cnt >= NOMAJ_LIMIT) begin
                    w_next_state = ST_FAIL;
                end else begin
                    w_next_nomaj = r_nomaj_cnt + 1'b1;
                end
            end
            default: begin
            end
        endcase
        if (rst) begin
            w_cnt_en    = 1'b0;
            w_load_en   = 3'b000;
            w_err_pulse = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_MONITOR;
            r_sel       <= '0;
            r_nomaj_cnt <= '0;
            r_q_out     <= '0;
            r_fail      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_fault_cnt[i] <= '0;
            end
        end else begin
            r_state     <= w_next_state;
            r_sel       <= w_next_sel;
            r_nomaj_cnt <= w_next_nomaj;
            if (w_next_state == ST_FAIL) begin
                r_fail <= 1'b1;
            end
            if (r_state != ST_FAIL && !w_no_maj) begin
                r_q_out <= w_maj;
            end
            for (int i = 0; i < 3; i++) begin
                if (w_fault_inc && w_next_sel == 2'(i) && r_fault_cnt[i] != ERR_MAX) begin
                    r_fault_cnt[i] <= r_fault_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.cnt_en    = w_cnt_en;
    assign bus.load_en   = w_load_en;
    assign bus.load_val  = w_maj;
    assign bus.err_pulse = w_err_pulse;
    assign bus.q_out     = r_q_out;
    assign bus.fail      = r_fail;
    assign bus.state     = r_state;
    assign bus.fault_cnt = {r_fault_cnt[2], r_fault_cnt[1], r_fault_cnt[0]};

endmodule
